pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL wrapper, in the clk_100MHz domain.
- Consumes the asynchronous pll_locked status and qualifies it as stable.
- Releases staged active-low resets to the core and DSP logic, then raises sys_ready.
- Generates the 2 MHz single-cycle clock-enable tick used by slow logic; lock loss tears everything down and restarts the sequence.

Parameters:
SYNC_STAGES, 2, synchroniser flops on pll_locked (min 2)
LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before first release
STAGE_DELAY, 16, cycles between core release, DSP release and sys_ready
TICK_DIV, 50, clk_100MHz cycles per tick_2MHz pulse (100/50 = 2 MHz)

Ports:
clk_100MHz  in  1  system clock, 100 MHz from PLL
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock status, asynchronous to clk_100MHz
core_rst_n  out  1  active-low reset to core logic
dsp_rst_n  out  1  active-low reset to DSP/measurement logic
sys_ready  out  1  high when sequence complete and lock held
tick_2MHz  out  1  one-cycle enable pulse every TICK_DIV cycles while sys_ready
lock_loss_count  out  8  saturating count of lock losses after first release

Behaviour:
- Reset: rst_n=0 asynchronously clears the synchroniser, counters and FSM (WAIT_LOCK). It also forces core_rst_n=0, dsp_rst_n=0, sys_ready=0, tick_2MHz=0 and lock_loss_count=0.
- Synchroniser: pll_locked passes through SYNC_STAGES flops to give lock_sync. No other logic samples pll_locked directly.
- All outputs are registered and decoded from the state register; no combinational path from inputs to outputs.
- FSM states: WAIT_LOCK, STABILIZE, CORE_UP, DSP_UP, RUN.
- WAIT_LOCK: on lock_sync=1, go to STABILIZE and clear the stage counter.
- STABILIZE: the counter increments on each cycle with lock_sync=1. When the counter reaches LOCK_STABLE-1 with lock_sync=1, go to CORE_UP. The FSM spends exactly LOCK_STABLE cycles in STABILIZE.
- CORE_UP: core_rst_n=1. Stay STAGE_DELAY cycles, then go to DSP_UP.
- DSP_UP: core_rst_n=1, dsp_rst_n=1. Stay STAGE_DELAY cycles, then go to RUN.
- RUN: core_rst_n=1, dsp_rst_n=1, sys_ready=1. Tick generator enabled.
- Lock loss (lock_sync=0) in any state other than WAIT_LOCK:
  - next state is WAIT_LOCK;
  - all reset outputs are low, and sys_ready and tick_2MHz are 0, from the following edge;
  - the stage counter clears.
- Glitch handling: a lock drop shorter than one cycle that the synchroniser does not capture has no effect. A captured drop during STABILIZE restarts qualification from zero.
- lock_loss_count: increments by 1 on a lock loss from CORE_UP, DSP_UP or RUN only. It saturates at 255 and never wraps. It clears only on rst_n.
- Tick generator:
  - The divider clears to 0 on entry to RUN and counts 0..TICK_DIV-1, then wraps to 0.
  - tick_2MHz=1 for exactly one cycle when the divider equals TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after sys_ready rises.
  - The divider holds at 0 outside RUN.
- Timing, with the first edge sampling pll_locked=1 as edge 0 and defaults:
  - lock_sync rises at edge 1 (SYNC_STAGES-1).
  - STABILIZE is entered at edge 2.
  - core_rst_n rises at edge 2+LOCK_STABLE = 1026.
  - dsp_rst_n rises at 1042.
  - sys_ready rises at 1058.
  - The first tick_2MHz is at 1108, then every 50 edges.
- Simultaneous events: rst_n assertion overrides everything. Lock loss on the same edge as a stage-counter terminal count takes the WAIT_LOCK path.
- Reset mid-sequence: release of rst_n restarts from WAIT_LOCK. Lock already present requires the full LOCK_STABLE qualification again.
- Widths: the stage counter is sized by $clog2 of max(LOCK_STABLE, STAGE_DELAY); the divider by $clog2(TICK_DIV). Parameter values below 1 are illegal and rejected by an elaboration assertion.

Test Plan:
- Clean start: rst_n low 10 cycles, release with pll_locked=1 held -> core_rst_n at edge 1026, dsp_rst_n 1042, sys_ready 1058, tick_2MHz pulses at 1108, 1158, 1208, each one cycle wide.
- Lock chatter in STABILIZE: drop pll_locked for 3 cycles at STABILIZE count 500 -> return to WAIT_LOCK, full 1024-cycle qualification restarts, lock_loss_count stays 0.
- Lock loss in RUN: drop pll_locked for 5 cycles -> core_rst_n, dsp_rst_n, sys_ready low 3 edges after the drop (2 sync + 1), ticks stop, lock_loss_count=1, full sequence repeats on relock.
- Loss during DSP_UP (cycle 8 of 16) -> both resets low, lock_loss_count increments, no sys_ready seen.
- Saturation: force 260 lock losses from RUN (LOCK_STABLE=4, STAGE_DELAY=2 override) -> lock_loss_count reads 255 and holds.
- Async reset mid-RUN: pulse rst_n low between clock edges -> all outputs 0 immediately without a clock edge, count=0, sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualification, staged reset release and 2 MHz tick
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int STAGE_DELAY = 16,
    parameter int TICK_DIV    = 50
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       core_rst_n,
    output logic       dsp_rst_n,
    output logic       sys_ready,
    output logic       tick_2MHz,
    output logic [7:0] lock_loss_count
);

    localparam int CNT_MAX = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);

    generate
        if (SYNC_STAGES < 2 || LOCK_STABLE < 1 || STAGE_DELAY < 1 || TICK_DIV < 1) begin : g_bad_param
            $error("pll_reset_sequencer: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABILIZE,
        CORE_UP,
        DSP_UP,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [7:0]             loss_q, loss_d;
    logic                   core_q, core_d;
    logic                   dsp_q, dsp_d;
    logic                   ready_q, ready_d;
    logic                   tick_q, tick_d;
    logic                   lock_sync;

    assign lock_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = '0;
        loss_d  = loss_q;
        // Lock loss outranks every terminal count, so it is decoded first.
        if (state_q != WAIT_LOCK && !lock_sync) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (state_q != STABILIZE && loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_sync) begin
                        state_d = STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (cnt_q == STAB_LAST) begin
                        state_d = CORE_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CORE_UP: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = DSP_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DSP_UP: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        core_d  = (state_d == CORE_UP) || (state_d == DSP_UP) || (state_d == RUN);
        dsp_d   = (state_d == DSP_UP) || (state_d == RUN);
        ready_d = (state_d == RUN);
        tick_d  = (state_q == RUN) && (state_d == RUN) && (div_q == DIV_LAST);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            div_q   <= '0;
            loss_q  <= '0;
            core_q  <= 1'b0;
            dsp_q   <= 1'b0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            loss_q  <= loss_d;
            core_q  <= core_d;
            dsp_q   <= dsp_d;
            ready_q <= ready_d;
            tick_q  <= tick_d;
        end
    end

    assign core_rst_n      = core_q;
    assign dsp_rst_n       = dsp_q;
    assign sys_ready       = ready_q;
    assign tick_2MHz       = tick_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int LS = 1024;
    localparam int SD = 16;
    localparam int TD = 50;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       core_rst_n, dsp_rst_n, sys_ready, tick_2MHz;
    logic [7:0] lock_loss_count;

    logic       rst_s_n;
    logic       locked_s;
    logic       s_core, s_dsp, s_ready, s_tick;
    logic [7:0] s_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [11:0] prev_vec;
    logic [11:0] obs_vec;

    typedef struct {
        int          cyc;
        logic [11:0] vec;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    pll_reset_sequencer dut (
        .clk_100MHz     (clk_100MHz),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .core_rst_n     (core_rst_n),
        .dsp_rst_n      (dsp_rst_n),
        .sys_ready      (sys_ready),
        .tick_2MHz      (tick_2MHz),
        .lock_loss_count(lock_loss_count)
    );

    pll_reset_sequencer #(.LOCK_STABLE(4), .STAGE_DELAY(2)) dut_s (
        .clk_100MHz     (clk_100MHz),
        .rst_n          (rst_s_n),
        .pll_locked     (locked_s),
        .core_rst_n     (s_core),
        .dsp_rst_n      (s_dsp),
        .sys_ready      (s_ready),
        .tick_2MHz      (s_tick),
        .lock_loss_count(s_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    assign obs_vec = {core_rst_n, dsp_rst_n, sys_ready, tick_2MHz, lock_loss_count};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [11:0] mk(input logic c, input logic d, input logic r,
                                       input logic t, input logic [7:0] n);
        return {c, d, r, t, n};
    endfunction

    task automatic push(input int c, input logic [11:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Expected output transitions of one qualification run whose first lock-sampling edge is e0.
    task automatic push_seq(input int e0, input logic [7:0] n, input int nstages, input int nticks);
        int rdy;
        rdy = e0 + 2 + LS + 2 * SD;
        push(e0 + 2 + LS, mk(1, 0, 0, 0, n), "core_up");
        if (nstages > 1) push(e0 + 2 + LS + SD, mk(1, 1, 0, 0, n), "dsp_up");
        if (nstages > 2) begin
            push(rdy, mk(1, 1, 1, 0, n), "sys_ready");
            for (int k = 0; k < nticks; k++) begin
                push(rdy + TD * (k + 1), mk(1, 1, 1, 1, n), "tick_hi");
                push(rdy + TD * (k + 1) + 1, mk(1, 1, 1, 0, n), "tick_lo");
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_100MHz);
    endtask

    always @(negedge clk_100MHz) begin
        if (mon_en && obs_vec !== prev_vec) begin
            if (sb_q.size() == 0) begin
                check("unexpected_change", obs_vec, prev_vec);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_cycle"}, cyc, e.cyc);
                check(e.tag, obs_vec, e.vec);
            end
            prev_vec = obs_vec;
        end
    end

    initial begin
        int e0;
        int c1;
        int n;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        rst_s_n    = 1'b0;
        locked_s   = 1'b0;
        repeat (10) @(negedge clk_100MHz);
        check("rst_core", core_rst_n, 0);
        check("rst_dsp", dsp_rst_n, 0);
        check("rst_ready", sys_ready, 0);
        check("rst_tick", tick_2MHz, 0);
        check("rst_count", lock_loss_count, 0);
        prev_vec = obs_vec;
        mon_en   = 1'b1;

        rst_n = 1'b1;
        e0 = cyc + 1;
        push_seq(e0, 8'd0, 3, 3);
        wait_cyc(e0 + 1230);

        c1 = cyc;
        pll_locked = 1'b0;
        push(c1 + 3, mk(0, 0, 0, 0, 8'd1), "run_loss");
        wait_cyc(c1 + 5);
        pll_locked = 1'b1;
        e0 = cyc + 1;

        wait_cyc(e0 + 502);
        pll_locked = 1'b0;
        wait_cyc(e0 + 505);
        pll_locked = 1'b1;
        e0 = cyc + 1;
        push_seq(e0, 8'd1, 2, 0);
        wait_cyc(e0 + 1047);
        pll_locked = 1'b0;
        push(e0 + 1050, mk(0, 0, 0, 0, 8'd2), "dsp_loss");
        wait_cyc(e0 + 1052);
        pll_locked = 1'b1;
        e0 = cyc + 1;
        push_seq(e0, 8'd2, 3, 1);
        wait_cyc(e0 + 1120);
        check("pre_async_count", lock_loss_count, 2);

        @(posedge clk_100MHz);
        #2 rst_n = 1'b0;
        push(cyc, mk(0, 0, 0, 0, 8'd0), "async_rst");
        #1;
        check("async_core", core_rst_n, 0);
        check("async_dsp", dsp_rst_n, 0);
        check("async_ready", sys_ready, 0);
        check("async_tick", tick_2MHz, 0);
        check("async_count", lock_loss_count, 0);
        rst_n = 1'b1;
        e0 = cyc + 1;
        push_seq(e0, 8'd0, 3, 1);
        wait_cyc(e0 + 1115);
        check("sb_drained", sb_q.size(), 0);
        mon_en = 1'b0;

        @(negedge clk_100MHz);
        rst_s_n = 1'b1;
        for (int i = 0; i < 260; i++) begin
            locked_s = 1'b1;
            n = 0;
            while (!s_ready && n < 40) begin
                @(negedge clk_100MHz);
                n++;
            end
            check("sat_ready", s_ready, 1);
            locked_s = 1'b0;
            repeat (4) @(negedge clk_100MHz);
            check("sat_down", {s_core, s_dsp, s_ready}, 0);
            check("sat_count", s_count, (i < 255) ? i + 1 : 255);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
